// File: rtl/pipe_exe_md.sv
// Execute stage: single-cycle ALU/JAL path plus an iterative multiply/divide
// unit with HI/LO registers that stalls IF/ID/EXE while it works.
module pipe_exe_md #(
    parameter int          WIDTH  = 32,
    parameter logic [4:0]  RA_REG = 5'd31
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [2:0]       emd_op,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] epc4,
    input  logic [4:0]       ern0,
    output logic [4:0]       ern,
    output logic [WIDTH-1:0] ealu,
    output logic             estall,
    output logic             ebusy,
    output logic [WIDTH-1:0] ehi,
    output logic [WIDTH-1:0] elo
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t        state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // mult: product high half; div: remainder
    logic [WIDTH-1:0] sh_q, sh_d;       // mult: multiplier/product low; div: dividend/quotient
    logic [WIDTH-1:0] bm_q, bm_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [SW-1:0]    shamt;
    logic             md_req;

    always_comb begin
        alu_a = eshift ? eimm : ea;
        alu_b = ealuimm ? eimm : eb;
        shamt = alu_a[SW-1:0];
        case (ealuc)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0100: alu_res = alu_a - alu_b;
            4'b0001: alu_res = alu_a & alu_b;
            4'b0101: alu_res = alu_a | alu_b;
            4'b0010: alu_res = alu_a ^ alu_b;
            4'b0110: alu_res = alu_b << (WIDTH / 2);
            4'b0011: alu_res = alu_b << shamt;
            4'b0111: alu_res = alu_b >> shamt;
            4'b1111: alu_res = $signed(alu_b) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    assign md_req = (emd_op >= 3'd1) && (emd_op <= 3'd4);

    always_comb begin
        ealu = alu_res;
        ern  = ern0;
        if (ejal) begin
            ealu = epc4 + WIDTH'(4);
            ern  = RA_REG;
        end else if (emd_op == 3'd5) begin
            ealu = hi_q;
        end else if (emd_op == 3'd6) begin
            ealu = lo_q;
        end else if (md_req) begin
            ern = 5'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        estall  = 1'b0;
        ebusy   = 1'b0;
        case (state_q)
            IDLE: begin
                estall = md_req;
                if (md_req) state_d = BUSY;
            end
            BUSY: begin
                estall = 1'b1;
                ebusy  = 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                ebusy   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic             sgn_op, sa, sb;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        bm_d     = bm_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn_op   = (emd_op == 3'd1) || (emd_op == 3'd3);
        sa       = sgn_op & ea[WIDTH-1];
        sb       = sgn_op & eb[WIDTH-1];
        sum      = {1'b0, acc_q} + (sh_q[0] ? {1'b0, bm_q} : '0);
        shifted  = {acc_q, sh_q[WIDTH-1]};
        diff     = shifted - {1'b0, bm_q};
        prod     = {acc_q, sh_q};
        case (state_q)
            IDLE: if (md_req) begin
                is_div_d = (emd_op >= 3'd3);
                acc_d    = '0;
                sh_d     = sa ? -ea : ea;
                bm_d     = sb ? -eb : eb;
                neg_lo_d = sa ^ sb;
                neg_hi_d = (emd_op >= 3'd3) ? sa : (sa ^ sb);
                dz_d     = (emd_op >= 3'd3) && (eb == '0);
                cnt_d    = SW'(WIDTH - 1);
            end
            BUSY: begin
                if (!is_div_q) begin
                    acc_d = sum[WIDTH:1];
                    sh_d  = {sum[0], sh_q[WIDTH-1:1]};
                end else if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q != '0) cnt_d = cnt_q - SW'(1);
            end
            DONE: begin
                if (!is_div_q) begin
                    if (neg_lo_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // A zero divisor leaves the dividend in the remainder; only LO is forced.
                    lo_d = dz_q ? '1 : (neg_lo_q ? -sh_q : sh_q);
                    hi_d = neg_hi_q ? -acc_q : acc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            bm_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            bm_q     <= bm_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign ehi = hi_q;
    assign elo = lo_q;
endmodule
